// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: turns instruction descriptors into 32-bit
// words and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_alu,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next, ptr_inc;
    logic              accept;
    logic              at_end;
    logic              we_next, done_next, err_next, busy_next;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       wdata_next;
    logic [PTR_W-1:0]  count_next;

    logic [31:0]       enc_word;
    logic              illegal;
    logic              alu_ok;
    logic [2:0]        funct3;
    logic [6:0]        funct7;

    // Descriptor to instruction word; illegal descriptors collapse to NOP
    always_comb begin
        illegal  = 1'b0;
        alu_ok   = 1'b1;
        funct3   = 3'b000;
        funct7   = (in_alu == 3'b001) ? 7'b0100000 : 7'b0000000;
        enc_word = NOP_WORD;
        case (in_alu)
            3'b000, 3'b001: funct3 = 3'b000;
            3'b010:         funct3 = 3'b111;
            3'b011:         funct3 = 3'b110;
            3'b101:         funct3 = 3'b010;
            default:        alu_ok = 1'b0;
        endcase
        case (in_class)
            3'd0: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
            3'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
            3'd2: begin
                if (!alu_ok) illegal = 1'b1;
                else enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, OP_REG};
            end
            3'd3: begin
                if (!alu_ok || in_alu == 3'b001) illegal = 1'b1;
                else enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, OP_IMM};
            end
            3'd4: begin
                if (in_imm[0]) illegal = 1'b1;
                else enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                                 in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            3'd5: begin
                if (in_imm[0]) illegal = 1'b1;
                else enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, OP_JAL};
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) enc_word = NOP_WORD;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        we_next    = 1'b0;
        done_next  = 1'b0;
        addr_next  = imem_addr;
        wdata_next = imem_wdata;
        err_next   = err;
        count_next = count;
        ptr_inc    = ptr + PTR_W'(1);
        at_end     = (ptr_inc == PTR_W'(DEPTH));
        in_ready   = (state == LOAD) && !start && (ptr < PTR_W'(DEPTH));
        accept     = in_valid && in_ready;

        if (start) begin
            state_next = LOAD;
            ptr_next   = '0;
            err_next   = 1'b0;
            count_next = '0;
        end else if (accept) begin
            ptr_next   = ptr_inc;
            we_next    = 1'b1;
            addr_next  = ptr[ADDR_W-1:0];
            wdata_next = enc_word;
            count_next = count + PTR_W'(1);
            err_next   = err || illegal || (at_end && !in_last);
            if (in_last || at_end) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
        busy_next = (state_next == LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            imem_we    <= we_next;
            imem_addr  <= addr_next;
            imem_wdata <= wdata_next;
            busy       <= busy_next;
            done       <= done_next;
            err        <= err_next;
            count      <= count_next;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed and random descriptor streams checked
// against a field-arithmetic reference model of the RV32I encodings.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start, start2;
    logic        in_valid;
    logic [2:0]  in_class;
    logic [2:0]  in_alu;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;
    logic        in_last;

    logic        in_ready, imem_we, busy, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    logic        in_ready2, imem_we2, busy2, done2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state for the 64-word instance
    int unsigned m_ptr, m_cnt;
    bit          m_err, m_load;
    localparam int unsigned M_DEPTH = 64;

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_class(in_class), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we2),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .busy(busy2), .done(done2),
        .err(err2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Encoding computed by weighting each field with its bit position
    function automatic void model_enc(input int unsigned cls, input int unsigned alu,
                                      input int unsigned rd, input int unsigned rs1,
                                      input int unsigned rs2, input int unsigned imm,
                                      output int unsigned w, output bit bad);
        int f3;
        bad = 1'b0;
        w   = 0;
        case (alu)
            0, 1: f3 = 0;
            2:    f3 = 7;
            3:    f3 = 6;
            5:    f3 = 2;
            default: f3 = -1;
        endcase
        case (cls)
            0: w = (imm % 4096) * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * 128 + 3;
            1: w = ((imm / 32) % 128) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                   + 2 * (1 << 12) + (imm % 32) * 128 + 35;
            2: begin
                bad = (f3 < 0);
                w = (alu == 1 ? 32'h4000_0000 : 0) + rs2 * (1 << 20) + rs1 * (1 << 15)
                    + int'(f3) * (1 << 12) + rd * 128 + 51;
            end
            3: begin
                bad = (f3 < 0) || (alu == 1);
                w = (imm % 4096) * (1 << 20) + rs1 * (1 << 15) + int'(f3) * (1 << 12)
                    + rd * 128 + 19;
            end
            4: begin
                bad = (imm % 2) == 1;
                w = ((imm / 4096) % 2) * 32'h8000_0000 + ((imm / 32) % 64) * (1 << 25)
                    + rs2 * (1 << 20) + rs1 * (1 << 15) + ((imm / 2) % 16) * 256
                    + ((imm / 2048) % 2) * 128 + 99;
            end
            5: begin
                bad = (imm % 2) == 1;
                w = ((imm / (1 << 20)) % 2) * 32'h8000_0000 + ((imm / 2) % 1024) * (1 << 21)
                    + ((imm / 2048) % 2) * (1 << 20) + ((imm / 4096) % 256) * (1 << 12)
                    + rd * 128 + 111;
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = 32'h13;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_common(input string tag, input bit exp_we, input bit exp_done);
        chk({tag, "_we"}, 32'(imem_we), 32'(exp_we));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_count"}, 32'(count), m_cnt);
        chk({tag, "_busy"}, 32'(busy), 32'(m_load));
    endtask

    task automatic send(input int unsigned cls, input int unsigned alu, input int unsigned rd,
                        input int unsigned rs1, input int unsigned rs2, input int unsigned imm,
                        input bit last);
        int unsigned w, p;
        bit bad, acc, fin;
        in_valid = 1'b1;
        in_class = 3'(cls);
        in_alu   = 3'(alu);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = 21'(imm);
        in_last  = last;
        #1;
        acc = m_load && (m_ptr < M_DEPTH);
        chk("in_ready", 32'(in_ready), 32'(acc));
        tick();
        fin = 1'b0;
        w = 0;
        p = m_ptr;
        if (acc) begin
            model_enc(cls, alu, rd, rs1, rs2, imm, w, bad);
            m_ptr++;
            m_cnt++;
            fin = last || (m_ptr == M_DEPTH);
            m_err = m_err || bad || (m_ptr == M_DEPTH && !last);
            if (fin) m_load = 1'b0;
        end
        check_common("send", acc, fin);
        if (acc) begin
            chk("addr", 32'(imem_addr), p);
            chk("wdata", imem_wdata, w);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_common("idle", 1'b0, 1'b0);
        end
    endtask

    task automatic do_start(input bit keep_valid);
        start    = 1'b1;
        in_valid = keep_valid;
        #1;
        chk("start_ready", 32'(in_ready), 32'(0));
        tick();
        start  = 1'b0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_load = 1'b1;
        check_common("start", 1'b0, 1'b0);
    endtask

    initial begin
        int unsigned len, cls, imm;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
        in_class = '0; in_alu = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_last = 1'b0;
        m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_load = 1'b0;
        repeat (2) tick();
        chk("rst_we", 32'(imem_we), 32'(0));
        chk("rst_addr", 32'(imem_addr), 32'(0));
        chk("rst_wdata", imem_wdata, 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b1;
        idle(2);

        // Single R-type add, last
        do_start(1'b0);
        send(2, 0, 3, 1, 2, 0, 1'b1);
        chk("tp_add", imem_wdata, 32'h0020_81B3);
        idle(1);

        // Back-to-back program with valid held high
        do_start(1'b0);
        send(2, 1, 5, 6, 7, 0, 1'b0);
        chk("tp_sub", imem_wdata, 32'h4073_02B3);
        send(0, 0, 2, 1, 0, 8, 1'b0);
        chk("tp_lw", imem_wdata, 32'h0080_A103);
        send(1, 0, 0, 1, 2, 4, 1'b0);
        chk("tp_sw", imem_wdata, 32'h0020_A223);
        send(4, 0, 0, 1, 2, 21'h1F_FFFC, 1'b0);
        chk("tp_beq", imem_wdata, 32'hFE20_8EE3);
        send(5, 0, 1, 0, 0, 8, 1'b1);
        chk("tp_jal", imem_wdata, 32'h0080_00EF);
        chk("tp_count5", 32'(count), 32'(5));
        idle(1);

        // Illegal descriptors become NOP and leave err sticky
        do_start(1'b0);
        send(3, 1, 4, 0, 0, 0, 1'b0);
        chk("tp_ill_ialu", imem_wdata, 32'h13);
        send(4, 0, 0, 1, 2, 3, 1'b0);
        chk("tp_ill_beq", imem_wdata, 32'h13);
        chk("tp_err_set", 32'(err), 32'(1));
        idle(2);
        send(2, 2, 9, 10, 11, 0, 1'b1);
        chk("tp_err_sticky", 32'(err), 32'(1));
        idle(1);

        // Restart mid-load after two writes
        do_start(1'b0);
        send(2, 3, 1, 2, 3, 0, 1'b0);
        send(3, 5, 4, 5, 0, 21'h00_07FF, 1'b0);
        do_start(1'b1);
        send(0, 0, 7, 8, 0, 21'h00_0123, 1'b0);
        chk("tp_restart_addr", 32'(imem_addr), 32'(0));
        chk("tp_restart_count", 32'(count), 32'(1));

        // Synchronous reset right after an acceptance
        send(1, 0, 0, 3, 4, 21'h00_0FFF, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_load = 1'b0;
        chk("rst2_we", 32'(imem_we), 32'(0));
        chk("rst2_addr", 32'(imem_addr), 32'(0));
        chk("rst2_wdata", imem_wdata, 32'(0));
        chk("rst2_done", 32'(done), 32'(0));
        check_common("rst2", 1'b0, 1'b0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst2_ready", 32'(in_ready), 32'(0));
            tick();
            check_common("rst2_idle", 1'b0, 1'b0);
        end
        in_valid = 1'b0;

        // Capacity overflow on a four-word instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            int unsigned w;
            bit bad;
            in_valid = 1'b1;
            in_class = 3'd2; in_alu = 3'd0;
            in_rd = 5'(i + 1); in_rs1 = 5'(i + 2); in_rs2 = 5'(i + 3);
            in_imm = '0; in_last = (i == 4);
            model_enc(2, 0, i + 1, i + 2, i + 3, 0, w, bad);
            #1;
            chk("ovf_ready", 32'(in_ready2), 32'(i < 4));
            tick();
            chk("ovf_we", 32'(imem_we2), 32'(i < 4));
            if (i < 4) begin
                chk("ovf_addr", 32'(imem_addr2), 32'(i));
                chk("ovf_wdata", imem_wdata2, w);
                chk("ovf_count", 32'(count2), 32'(i + 1));
            end
            chk("ovf_done", 32'(done2), 32'(i == 3));
            chk("ovf_err", 32'(err2), 32'(i >= 3));
            chk("ovf_busy", 32'(busy2), 32'(i < 3));
            chk("ovf_main_we", 32'(imem_we), 32'(0));
        end
        chk("ovf_count_final", 32'(count2), 32'(4));
        in_valid = 1'b0;
        in_last = 1'b0;

        // Random programs with occasional valid gaps
        for (int prog = 0; prog < 3; prog++) begin
            do_start(1'b0);
            len = $urandom_range(8, 18);
            for (int k = 0; k < int'(len); k++) begin
                cls = $urandom_range(0, 7);
                imm = $urandom & 32'h1F_FFFF;
                if ((cls == 4 || cls == 5) && ($urandom % 4 != 0)) imm = imm & ~32'h1;
                send(cls, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), imm, k == int'(len) - 1);
                if ($urandom % 4 == 0) idle(1);
            end
            idle(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
